// File: rtl/atpg_vector_player_pkg.sv
// Shared types and defaults for the ATPG vector player and its MISR.
// Holds the FSM state encoding and the default MISR feedback taps per response width.
package atpg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_CAPTURE,
    ST_DONE
  } atpg_state_t;

  // The settle counter only needs to cover SETTLE values 0..15.
  localparam int SETTLE_W = 4;

  function automatic logic [31:0] misr_default_poly(input int width);
    logic [31:0] poly;
    case (width)
      2:       poly = 32'h0000_0003;
      3:       poly = 32'h0000_0006;
      4:       poly = 32'h0000_000C;
      5:       poly = 32'h0000_0014;
      6:       poly = 32'h0000_0030;
      7:       poly = 32'h0000_0060;
      8:       poly = 32'h0000_00B8;
      16:      poly = 32'h0000_B400;
      default: poly = 32'h0000_0001 << (width - 1);
    endcase
    return poly;
  endfunction

endpackage

// File: rtl/atpg_vector_player_if.sv
// Control, result and DUT-facing signals of the ATPG vector player.
// The player uses the slave modport; the controlling side uses master.
interface atpg_vector_player_if #(
  parameter int IN_W  = 17,
  parameter int OUT_W = 5,
  parameter int AW    = 6,
  parameter int CW    = 8
);

  logic             load_we;
  logic [AW-1:0]    load_addr;
  logic [IN_W-1:0]  load_vec;
  logic [OUT_W-1:0] load_exp;
  logic [OUT_W-1:0] load_mask;
  logic [AW:0]      num_vec;
  logic             start;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out;
  logic             busy;
  logic             done;
  logic [AW-1:0]    vec_idx;
  logic [CW-1:0]    fail_cnt;
  logic [AW-1:0]    first_fail;
  logic             fail_vld;
  logic [OUT_W-1:0] signature;

  modport slave (
    input  load_we, load_addr, load_vec, load_exp, load_mask, num_vec, start, dut_out,
    output dut_in, busy, done, vec_idx, fail_cnt, first_fail, fail_vld, signature
  );

  modport master (
    output load_we, load_addr, load_vec, load_exp, load_mask, num_vec, start, dut_out,
    input  dut_in, busy, done, vec_idx, fail_cnt, first_fail, fail_vld, signature
  );

endinterface

// File: rtl/atpg_vector_player_misr.sv
// Multiple-input signature register folding every captured DUT response.
// Clear has priority over enable; both are synchronous like the reset.
module atpg_misr
  import atpg_pkg::*;
#(
  parameter int               OUT_W     = 5,
  parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(misr_default_poly(OUT_W))
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [OUT_W-1:0] i_data,
  output logic [OUT_W-1:0] o_sig
);

  logic [OUT_W-1:0] r_sig;
  logic [OUT_W-1:0] w_fb;

  assign w_fb = r_sig[OUT_W-1] ? MISR_POLY : '0;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sig <= '0;
    end else if (i_clr) begin
      r_sig <= '0;
    end else if (i_en) begin
      r_sig <= {r_sig[OUT_W-2:0], 1'b0} ^ w_fb ^ i_data;
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/atpg_vector_player.sv
// Clocked vector applicator: drives stored stimuli onto a DUT, waits SETTLE clocks,
// compares the masked response with the expected value and folds it into a MISR.
module atpg_vector_player
  import atpg_pkg::*;
#(
  parameter int               IN_W      = 17,
  parameter int               OUT_W     = 5,
  parameter int               DEPTH     = 50,
  parameter int               AW        = 6,
  parameter int               SETTLE    = 3,
  parameter int               CW        = 8,
  parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(misr_default_poly(OUT_W))
) (
  input logic                 CK,
  input logic                 RST_N,
  atpg_vector_player_if.slave bus
);

  typedef struct packed {
    logic [IN_W-1:0]  vec;
    logic [OUT_W-1:0] exp;
    logic [OUT_W-1:0] mask;
  } entry_t;

  entry_t              r_mem [DEPTH];
  atpg_state_t         r_state;
  atpg_state_t         w_next;
  logic [AW:0]         r_n;
  logic [AW:0]         w_n;
  logic [SETTLE_W-1:0] r_settle;
  logic [IN_W-1:0]     r_dut_in;
  logic [AW-1:0]       r_vec_idx;
  logic [AW-1:0]       r_first_fail;
  logic [CW-1:0]       r_fail_cnt;
  logic                r_fail_vld;
  logic [OUT_W-1:0]    w_sig;
  entry_t              w_entry;
  logic                w_we;
  logic                w_last;
  logic                w_mismatch;
  logic                w_busy;
  logic                w_done;
  logic                w_accept;
  logic                w_apply;
  logic                w_wait;
  logic                w_capture;

  // Run length is clamped to the memory size when the run is launched.
  assign w_n        = (bus.num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.num_vec;
  assign w_entry    = r_mem[r_vec_idx];
  assign w_last     = ({1'b0, r_vec_idx} == (r_n - (AW+1)'(1)));
  assign w_mismatch = |((bus.dut_out ^ w_entry.exp) & w_entry.mask);
  assign w_we       = bus.load_we && !w_busy && ({1'b0, bus.load_addr} < (AW+1)'(DEPTH));

  // NOTE: the vector memory has no reset so it can map onto plain RAM; its
  // contents survive RST_N and are only defined once loaded.
  always_ff @(posedge CK) begin
    if (w_we) begin
      r_mem[bus.load_addr] <= '{vec: bus.load_vec, exp: bus.load_exp, mask: bus.load_mask};
    end
  end

  // NOTE: flops are written with <= so every register samples pre-edge values,
  // regardless of the order of statements or processes.
  always_ff @(posedge CK) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:    if (bus.start) w_next = (w_n == '0) ? ST_DONE : ST_APPLY;
      ST_APPLY:   w_next = (SETTLE == 0) ? ST_CAPTURE : ST_WAIT;
      ST_WAIT:    if (r_settle <= SETTLE_W'(1)) w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = w_last ? ST_DONE : ST_APPLY;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy    = 1'b0;
    w_done    = 1'b0;
    w_accept  = 1'b0;
    w_apply   = 1'b0;
    w_wait    = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE:    w_accept = bus.start;
      ST_APPLY:   begin w_busy = 1'b1; w_apply   = 1'b1; end
      ST_WAIT:    begin w_busy = 1'b1; w_wait    = 1'b1; end
      ST_CAPTURE: begin w_busy = 1'b1; w_capture = 1'b1; end
      ST_DONE:    w_done = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge CK) begin
    if (!RST_N) begin
      r_n          <= '0;
      r_settle     <= '0;
      r_dut_in     <= '0;
      r_vec_idx    <= '0;
      r_first_fail <= '0;
      r_fail_cnt   <= '0;
      r_fail_vld   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_n          <= w_n;
        r_vec_idx    <= '0;
        r_first_fail <= '0;
        r_fail_cnt   <= '0;
        r_fail_vld   <= 1'b0;
      end
      if (w_apply) begin
        r_dut_in <= w_entry.vec;
        r_settle <= SETTLE_W'(SETTLE);
      end
      if (w_wait) begin
        r_settle <= r_settle - SETTLE_W'(1);
      end
      if (w_capture) begin
        if (w_mismatch) begin
          if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + CW'(1);
          if (!r_fail_vld) begin
            r_first_fail <= r_vec_idx;
            r_fail_vld   <= 1'b1;
          end
        end
        if (!w_last) r_vec_idx <= r_vec_idx + AW'(1);
      end
    end
  end

  atpg_misr #(
    .OUT_W    (OUT_W),
    .MISR_POLY(MISR_POLY)
  ) u_misr (
    .i_clk  (CK),
    .i_rst_n(RST_N),
    .i_clr  (w_accept),
    .i_en   (w_capture),
    .i_data (bus.dut_out),
    .o_sig  (w_sig)
  );

  assign bus.dut_in     = r_dut_in;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.vec_idx    = r_vec_idx;
  assign bus.fail_cnt   = r_fail_cnt;
  assign bus.first_fail = r_first_fail;
  assign bus.fail_vld   = r_fail_vld;
  assign bus.signature  = w_sig;

endmodule

// File: tb/tb_atpg_vector_player.sv
// Directed bench for atpg_vector_player driving a small combinational DUT model.
// Each scenario task checks its own results against hand-derived values.
module tb_atpg_vector_player;

  localparam int               IN_W   = 17;
  localparam int               OUT_W  = 5;
  localparam int               DEPTH  = 50;
  localparam int               AW     = 6;
  localparam int               SETTLE = 3;
  localparam int               CW     = 8;
  localparam logic [OUT_W-1:0] POLY   = 5'b10100;

  logic clk;
  logic rst_n;
  logic             ovr;
  logic [OUT_W-1:0] ovr_val;
  int n_tests;
  int n_fail;

  atpg_vector_player_if #(.IN_W(IN_W), .OUT_W(OUT_W), .AW(AW), .CW(CW)) bus ();

  atpg_vector_player #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .AW(AW),
    .SETTLE(SETTLE), .CW(CW), .MISR_POLY(POLY)
  ) dut (
    .CK   (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] v);
    return v[4:0] ^ v[9:5] ^ v[14:10] ^ {3'b000, v[16:15]};
  endfunction

  function automatic logic [OUT_W-1:0] misr_ref(input logic [OUT_W-1:0] s,
                                                input logic [OUT_W-1:0] d);
    logic [OUT_W-1:0] n;
    n = {s[OUT_W-2:0], 1'b0} ^ d;
    if (s[OUT_W-1]) n = n ^ POLY;
    return n;
  endfunction

  function automatic logic [IN_W-1:0] vec_of(input int i);
    case (i)
      0:       return 17'h00001;
      1:       return 17'h1F0A3;
      2:       return 17'h0ABCD;
      3:       return 17'h15555;
      default: return 17'(i * 2731 + 77);
    endcase
  endfunction

  assign bus.dut_out = ovr ? ovr_val : model(bus.dut_in);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_entry(input int addr, input logic [IN_W-1:0] vec,
                            input logic [OUT_W-1:0] exp, input logic [OUT_W-1:0] mask);
    bus.load_we   = 1'b1;
    bus.load_addr = AW'(addr);
    bus.load_vec  = vec;
    bus.load_exp  = exp;
    bus.load_mask = mask;
    tick();
    bus.load_we = 1'b0;
  endtask

  task automatic run_vectors(input logic [AW:0] num, output int cycles, output bit busy_seen);
    bus.num_vec = num;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    cycles    = 1;
    busy_seen = (bus.busy === 1'b1);
    while (bus.done !== 1'b1 && cycles < 1000) begin
      tick();
      cycles++;
      if (bus.busy === 1'b1) busy_seen = 1'b1;
    end
    n_tests++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL run_timeout num_vec=%0d: done not seen after %0d clocks", num, cycles);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_tests++; if (bus.dut_in !== '0) begin n_fail++; $display("FAIL reset_dut_in got %h want 0", bus.dut_in); end
    n_tests++; if (bus.vec_idx !== '0) begin n_fail++; $display("FAIL reset_vec_idx got %0d want 0", bus.vec_idx); end
    n_tests++; if (bus.fail_cnt !== '0) begin n_fail++; $display("FAIL reset_fail_cnt got %0d want 0", bus.fail_cnt); end
    n_tests++; if (bus.first_fail !== '0) begin n_fail++; $display("FAIL reset_first_fail got %0d want 0", bus.first_fail); end
    n_tests++; if (bus.fail_vld !== 1'b0) begin n_fail++; $display("FAIL reset_fail_vld got %b want 0", bus.fail_vld); end
    n_tests++; if (bus.signature !== '0) begin n_fail++; $display("FAIL reset_signature got %b want 0", bus.signature); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int cycles;
    bit busy_seen;
    logic [OUT_W-1:0] sig;
    sig = '0;
    for (int i = 0; i < 4; i++) begin
      load_entry(i, vec_of(i), model(vec_of(i)), 5'b11111);
      sig = misr_ref(sig, model(vec_of(i)));
    end
    run_vectors(7'd4, cycles, busy_seen);
    n_tests++; if (cycles != 21) begin n_fail++; $display("FAIL basic_latency got %0d want 21", cycles); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done got %b want 0", bus.busy); end
    n_tests++; if (bus.fail_cnt !== 8'd0) begin n_fail++; $display("FAIL basic_fail_cnt got %0d want 0", bus.fail_cnt); end
    n_tests++; if (bus.fail_vld !== 1'b0) begin n_fail++; $display("FAIL basic_fail_vld got %b want 0", bus.fail_vld); end
    n_tests++; if (bus.signature !== sig) begin n_fail++; $display("FAIL basic_signature got %b want %b", bus.signature, sig); end
    n_tests++; if (bus.vec_idx !== 6'd3) begin n_fail++; $display("FAIL basic_vec_idx got %0d want 3", bus.vec_idx); end
    tick();
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", bus.done); end
    n_tests++; if (bus.dut_in !== vec_of(3)) begin n_fail++; $display("FAIL basic_dut_in_hold got %h want %h", bus.dut_in, vec_of(3)); end
  endtask

  task automatic test_mismatch();
    int cycles;
    bit busy_seen;
    load_entry(2, vec_of(2), model(vec_of(2)) ^ 5'b00001, 5'b00001);
    run_vectors(7'd4, cycles, busy_seen);
    n_tests++; if (bus.fail_cnt !== 8'd1) begin n_fail++; $display("FAIL mism_fail_cnt got %0d want 1", bus.fail_cnt); end
    n_tests++; if (bus.first_fail !== 6'd2) begin n_fail++; $display("FAIL mism_first_fail got %0d want 2", bus.first_fail); end
    n_tests++; if (bus.fail_vld !== 1'b1) begin n_fail++; $display("FAIL mism_fail_vld got %b want 1", bus.fail_vld); end
    // Second corrupted entry earlier in the run: first_fail must move to 1.
    load_entry(1, vec_of(1), model(vec_of(1)) ^ 5'b10000, 5'b11111);
    run_vectors(7'd4, cycles, busy_seen);
    n_tests++; if (bus.fail_cnt !== 8'd2) begin n_fail++; $display("FAIL mism2_fail_cnt got %0d want 2", bus.fail_cnt); end
    n_tests++; if (bus.first_fail !== 6'd1) begin n_fail++; $display("FAIL mism2_first_fail got %0d want 1", bus.first_fail); end
    load_entry(1, vec_of(1), model(vec_of(1)), 5'b11111);
    // Mask write and start in the same IDLE cycle: the run must see mask=0.
    bus.load_we   = 1'b1;
    bus.load_addr = 6'd2;
    bus.load_vec  = vec_of(2);
    bus.load_exp  = model(vec_of(2)) ^ 5'b00001;
    bus.load_mask = 5'b00000;
    run_vectors(7'd4, cycles, busy_seen);
    bus.load_we = 1'b0;
    n_tests++; if (bus.fail_cnt !== 8'd0) begin n_fail++; $display("FAIL mask0_fail_cnt got %0d want 0", bus.fail_cnt); end
    n_tests++; if (bus.fail_vld !== 1'b0) begin n_fail++; $display("FAIL mask0_fail_vld got %b want 0", bus.fail_vld); end
  endtask

  task automatic test_boundary();
    int cycles;
    bit busy_seen;
    for (int i = 0; i < DEPTH; i++) load_entry(i, vec_of(i), model(vec_of(i)), 5'b11111);
    run_vectors(7'd0, cycles, busy_seen);
    n_tests++; if (cycles != 1) begin n_fail++; $display("FAIL zero_latency got %0d want 1", cycles); end
    n_tests++; if (busy_seen) begin n_fail++; $display("FAIL zero_busy_seen got 1 want 0"); end
    n_tests++; if (bus.signature !== '0) begin n_fail++; $display("FAIL zero_signature got %b want 0", bus.signature); end
    tick();
    run_vectors(7'd63, cycles, busy_seen);
    n_tests++; if (cycles != 251) begin n_fail++; $display("FAIL clamp_latency got %0d want 251", cycles); end
    n_tests++; if (bus.vec_idx !== 6'd49) begin n_fail++; $display("FAIL clamp_vec_idx got %0d want 49", bus.vec_idx); end
    n_tests++; if (bus.fail_cnt !== 8'd0) begin n_fail++; $display("FAIL clamp_fail_cnt got %0d want 0", bus.fail_cnt); end
    tick();
  endtask

  task automatic test_misr();
    int cycles;
    bit busy_seen;
    ovr     = 1'b1;
    ovr_val = 5'b00001;
    run_vectors(7'd3, cycles, busy_seen);
    n_tests++; if (bus.signature !== 5'b00111) begin n_fail++; $display("FAIL misr_sig got %b want 00111", bus.signature); end
    tick();
    run_vectors(7'd3, cycles, busy_seen);
    n_tests++; if (bus.signature !== 5'b00111) begin n_fail++; $display("FAIL misr_repeat got %b want 00111", bus.signature); end
    ovr = 1'b0;
    tick();
  endtask

  task automatic test_reset_abort();
    int cycles;
    bit busy_seen;
    load_entry(1, vec_of(1), model(vec_of(1)) ^ 5'b00100, 5'b11111);
    bus.num_vec = 7'd10;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (27) tick();
    n_tests++; if (bus.vec_idx !== 6'd5 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_pre_state vec_idx=%0d busy=%b want 5/1", bus.vec_idx, bus.busy);
    end
    n_tests++; if (bus.fail_cnt !== 8'd1) begin n_fail++; $display("FAIL abort_pre_fail_cnt got %0d want 1", bus.fail_cnt); end
    rst_n = 1'b0;
    tick();
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", bus.busy); end
    n_tests++; if (bus.dut_in !== '0) begin n_fail++; $display("FAIL abort_dut_in got %h want 0", bus.dut_in); end
    n_tests++; if (bus.fail_cnt !== 8'd0) begin n_fail++; $display("FAIL abort_fail_cnt got %0d want 0", bus.fail_cnt); end
    n_tests++; if (bus.vec_idx !== '0) begin n_fail++; $display("FAIL abort_vec_idx got %0d want 0", bus.vec_idx); end
    rst_n = 1'b1;
    tick();
    load_entry(1, vec_of(1), model(vec_of(1)), 5'b11111);
    run_vectors(7'd6, cycles, busy_seen);
    n_tests++; if (cycles != 31) begin n_fail++; $display("FAIL rerun_latency got %0d want 31", cycles); end
    n_tests++; if (bus.fail_cnt !== 8'd0 || bus.vec_idx !== 6'd5) begin
      n_fail++; $display("FAIL rerun_result fail_cnt=%0d vec_idx=%0d want 0/5", bus.fail_cnt, bus.vec_idx);
    end
    tick();
  endtask

  task automatic test_busy_ignore();
    int cycles;
    bit busy_seen;
    bus.num_vec = 7'd4;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    // Mid-run: a new start and a corrupting write must both be ignored.
    bus.num_vec   = 7'd1;
    bus.start     = 1'b1;
    bus.load_we   = 1'b1;
    bus.load_addr = 6'd2;
    bus.load_vec  = vec_of(2);
    bus.load_exp  = ~model(vec_of(2));
    bus.load_mask = 5'b11111;
    tick();
    bus.start   = 1'b0;
    bus.load_we = 1'b0;
    cycles = 5;
    while (bus.done !== 1'b1 && cycles < 1000) begin
      tick();
      cycles++;
    end
    n_tests++; if (cycles != 21) begin n_fail++; $display("FAIL busy_latency got %0d want 21", cycles); end
    n_tests++; if (bus.fail_cnt !== 8'd0) begin n_fail++; $display("FAIL busy_fail_cnt got %0d want 0", bus.fail_cnt); end
    repeat (2) tick();
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_no_queue got %b want 0", bus.busy); end
    run_vectors(7'd4, cycles, busy_seen);
    n_tests++; if (bus.fail_cnt !== 8'd0 || bus.fail_vld !== 1'b0) begin
      n_fail++; $display("FAIL busy_mem_intact fail_cnt=%0d fail_vld=%b want 0/0", bus.fail_cnt, bus.fail_vld);
    end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    ovr           = 1'b0;
    ovr_val       = '0;
    bus.load_we   = 1'b0;
    bus.load_addr = '0;
    bus.load_vec  = '0;
    bus.load_exp  = '0;
    bus.load_mask = '0;
    bus.num_vec   = '0;
    bus.start     = 1'b0;
    test_reset();
    test_basic();
    test_mismatch();
    test_boundary();
    test_misr();
    test_reset_abort();
    test_busy_ignore();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
